// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: leaf packet layout and credit helpers shared by the leaf shell.
package leaf_pkt_pkg;
  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W = 5;
  localparam int PORT_W = 4;
  localparam int ADDR_W = 7;
  localparam int PACKET_W = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB = PAYLOAD_LSB + PAYLOAD_W;
  localparam int PORT_LSB = ADDR_LSB + ADDR_W;
  localparam int LEAF_LSB = PORT_LSB + PORT_W;
  localparam int VALID_BIT = LEAF_LSB + LEAF_W;
  typedef struct packed {
    logic valid;
    logic [LEAF_W-1:0] dest_leaf;
    logic [PORT_W-1:0] dest_port;
    logic [ADDR_W-1:0] addr;
    logic [PAYLOAD_W-1:0] payload;
  } leaf_packet_t;
  function automatic int credit_max(input int addr_bits);
    return 1 << addr_bits;
  endfunction
endpackage

// File: rtl/leaf_out_scheduler_if.sv
// leaf_out_scheduler_if: user-side streams, route config, credits and BFT packet link.
interface leaf_out_scheduler_if #(
  parameter int NUM_OUT_PORTS = 6,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int PACKET_BITS = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0] vld_user2interface;
  logic [NUM_OUT_PORTS-1:0] ack_interface2user;
  logic cfg_we;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_dest_port;
  logic [NUM_OUT_PORTS-1:0] credit_update;
  logic resend;
  logic [PACKET_BITS-1:0] dout_packet;
  logic dout_ready;
  modport master (
    output din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port, cfg_dest_leaf,
           cfg_dest_port, credit_update, resend, dout_ready,
    input  ack_interface2user, dout_packet
  );
  modport slave (
    input  din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port, cfg_dest_leaf,
           cfg_dest_port, credit_update, resend, dout_ready,
    output ack_interface2user, dout_packet
  );
endinterface

// File: rtl/leaf_out_scheduler_rr_arbiter.sv
// rr_arbiter: grants the first requester at or after ptr, cyclically.
module rr_arbiter #(
  parameter int N = 6,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    // scan downward so the lowest cyclic offset is the last writer
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (en && req[W'(j)]) begin
        grant = N'(1) << j;
        idx = W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/leaf_out_scheduler.sv
// leaf_out_scheduler: credit-gated round-robin mux of user output streams onto the BFT link.
module leaf_out_scheduler
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS = PACKET_W,
  parameter int PAYLOAD_BITS = PAYLOAD_W,
  parameter int NUM_LEAF_BITS = LEAF_W,
  parameter int NUM_PORT_BITS = PORT_W,
  parameter int NUM_ADDR_BITS = ADDR_W,
  parameter int NUM_OUT_PORTS = 6,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic clk,
  input logic reset,
  leaf_out_scheduler_if.slave bus
);
  localparam int W = NUM_OUT_PORTS > 1 ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW-1:0] CMAX = CW'(credit_max(NUM_ADDR_BITS));
  localparam logic [CW:0] UPD = (CW+1)'(FREESPACE_UPDATE_SIZE);
  logic [NUM_OUT_PORTS-1:0] cfg_valid, elig, grant;
  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr [NUM_OUT_PORTS];
  logic [CW-1:0] credit [NUM_OUT_PORTS];
  logic [CW-1:0] credit_nxt [NUM_OUT_PORTS];
  logic [CW:0] credit_sum [NUM_OUT_PORTS];
  logic [W-1:0] rr_ptr, idx;
  logic any, load;
  assign load = ~bus.dout_packet[PACKET_BITS-1] | bus.dout_ready;
  assign bus.ack_interface2user = grant;
  always_comb begin
    for (int n = 0; n < NUM_OUT_PORTS; n++)
      elig[n] = bus.vld_user2interface[n] & cfg_valid[n] & (credit[n] != '0) & ~bus.resend;
  end
  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .req(elig), .ptr(rr_ptr), .en(load), .grant(grant), .idx(idx), .any(any)
  );
  // a grant implies credit >= 1, so the sum never underflows
  always_comb begin
    for (int n = 0; n < NUM_OUT_PORTS; n++) begin
      credit_sum[n] = {1'b0, credit[n]} + (bus.credit_update[n] ? UPD : '0) - (CW+1)'(grant[n]);
      credit_nxt[n] = credit_sum[n] > {1'b0, CMAX} ? CMAX : credit_sum[n][CW-1:0];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout_packet <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      bus.dout_packet <= any ? {1'b1, dest_leaf[idx], dest_port[idx], addr[idx],
                                bus.din_leaf_user2interface[int'(idx)*PAYLOAD_BITS +: PAYLOAD_BITS]} : '0;
      if (any) rr_ptr <= idx == W'(NUM_OUT_PORTS - 1) ? '0 : idx + 1'b1;
    end
  end
  // a config write overrides the same-cycle send update on that port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_valid <= '0;
      for (int n = 0; n < NUM_OUT_PORTS; n++) begin
        dest_leaf[n] <= '0;
        dest_port[n] <= '0;
        addr[n] <= '0;
        credit[n] <= CMAX;
      end
    end else begin
      for (int n = 0; n < NUM_OUT_PORTS; n++) begin
        if (bus.cfg_we && bus.cfg_port == NUM_PORT_BITS'(n)) begin
          cfg_valid[n] <= 1'b1;
          dest_leaf[n] <= bus.cfg_dest_leaf;
          dest_port[n] <= bus.cfg_dest_port;
          addr[n] <= '0;
          credit[n] <= CMAX;
        end else begin
          addr[n] <= addr[n] + NUM_ADDR_BITS'(grant[n]);
          credit[n] <= credit_nxt[n];
        end
      end
    end
  end
endmodule

// File: tb/tb_leaf_out_scheduler.sv
// tb_leaf_out_scheduler: directed edge cases plus randomized traffic against a behavioural model.
module tb_leaf_out_scheduler;
  import leaf_pkt_pkg::*;
  localparam int N = 6;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  leaf_out_scheduler_if #(.NUM_OUT_PORTS(N)) bus ();
  leaf_out_scheduler #(.NUM_OUT_PORTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  bit m_cfg [N];
  int m_leaf [N], m_port [N], m_addr [N], m_cred [N];
  int m_ptr;
  logic [48:0] m_out;

  function automatic logic [48:0] pk(int leaf, int port, int addr, logic [31:0] d);
    leaf_packet_t p;
    p.valid = 1'b1;
    p.dest_leaf = LEAF_W'(leaf);
    p.dest_port = PORT_W'(port);
    p.addr = ADDR_W'(addr);
    p.payload = d;
    return p;
  endfunction

  function automatic int exp_grant();
    if ((m_out[48] && !bus.dout_ready) || bus.resend) return -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (bus.vld_user2interface[p] && m_cfg[p] && m_cred[p] > 0) return p;
    end
    return -1;
  endfunction

  function automatic logic [48:0] mk_out(int g);
    if (g < 0) return '0;
    return pk(m_leaf[g], m_port[g], m_addr[g], bus.din_leaf_user2interface[g*32 +: 32]);
  endfunction

  function automatic int cmin(int a);
    return a > 128 ? 128 : a;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr <= 0;
      m_out <= '0;
      for (int p = 0; p < N; p++) begin
        m_cfg[p] <= 1'b0;
        m_leaf[p] <= 0;
        m_port[p] <= 0;
        m_addr[p] <= 0;
        m_cred[p] <= 128;
      end
    end else begin
      if (!m_out[48] || bus.dout_ready) m_out <= mk_out(exp_grant());
      if (exp_grant() >= 0) m_ptr <= (exp_grant() + 1) % N;
      for (int p = 0; p < N; p++) begin
        if (bus.cfg_we && int'(bus.cfg_port) == p) begin
          m_cfg[p] <= 1'b1;
          m_leaf[p] <= int'(bus.cfg_dest_leaf);
          m_port[p] <= int'(bus.cfg_dest_port);
          m_addr[p] <= 0;
          m_cred[p] <= 128;
        end else begin
          if (exp_grant() == p) m_addr[p] <= (m_addr[p] + 1) % 128;
          m_cred[p] <= cmin(m_cred[p] - (exp_grant() == p ? 1 : 0) + (bus.credit_update[p] ? 64 : 0));
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_ack", 64'(bus.ack_interface2user), exp_grant() >= 0 ? 64'(1) << exp_grant() : 64'(0));
    chk("model_dout", 64'(bus.dout_packet), 64'(m_out));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int p, int leaf, int port);
    bus.cfg_we = 1'b1;
    bus.cfg_port = 4'(p);
    bus.cfg_dest_leaf = 5'(leaf);
    bus.cfg_dest_port = 4'(port);
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic setd(int p, logic [31:0] d);
    bus.din_leaf_user2interface[p*32 +: 32] = d;
  endtask

  task automatic count_acks(int cycles, int port, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      #2;
      if (bus.ack_interface2user[port]) cnt++;
      cyc();
    end
  endtask

  initial begin
    int order [6] = '{0, 2, 5, 0, 2, 5};
    int cnt;
    logic [N-1:0] acked;
    reset = 1'b1;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_port = '0;
    bus.cfg_dest_leaf = '0;
    bus.cfg_dest_port = '0;
    bus.credit_update = '0;
    bus.resend = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (3) cyc();
    #2;
    chk("reset_dout", 64'(bus.dout_packet), 64'(0));
    chk("reset_ack", 64'(bus.ack_interface2user), 64'(0));
    reset = 1'b0;
    cfg(1, 3, 2);
    setd(1, 32'hDEADBEEF);
    bus.vld_user2interface = 6'b000010;
    #2 chk("route_ack", 64'(bus.ack_interface2user), 64'(2));
    cyc();
    setd(1, 32'h12345678);
    #2 chk("route_pkt", 64'(bus.dout_packet), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
    cyc();
    bus.vld_user2interface = '0;
    #2 chk("route_addr1", 64'(bus.dout_packet), 64'(pk(3, 2, 1, 32'h12345678)));
    bus.vld_user2interface = 6'b000010;
    cyc();
    #1 reset = 1'b1;
    #1;
    chk("reset_async_dout", 64'(bus.dout_packet), 64'(0));
    chk("reset_async_ack", 64'(bus.ack_interface2user), 64'(0));
    cyc();
    reset = 1'b0;
    #2 chk("reconfig_needed", 64'(bus.ack_interface2user), 64'(0));
    cyc();
    bus.vld_user2interface = '0;
    cfg(0, 1, 1);
    cfg(2, 2, 2);
    cfg(5, 5, 5);
    setd(0, 32'h00000A00);
    setd(2, 32'h00000A02);
    setd(5, 32'h00000A05);
    bus.vld_user2interface = 6'b100101;
    for (int i = 0; i < 6; i++) begin
      #2 chk("fair_order", 64'(bus.ack_interface2user), 64'(1) << order[i]);
      cyc();
    end
    bus.vld_user2interface = '0;
    cfg(0, 1, 1);
    bus.vld_user2interface = 6'b000001;
    count_acks(140, 0, cnt);
    chk("credit_exhaust", 64'(cnt), 64'(128));
    #2 chk("credit_stall_ack", 64'(bus.ack_interface2user), 64'(0));
    cyc();
    bus.credit_update = 6'b000001;
    cyc();
    bus.credit_update = '0;
    count_acks(80, 0, cnt);
    chk("credit_refill_64", 64'(cnt), 64'(64));
    bus.credit_update = 6'b000001;
    cyc();
    bus.credit_update = '0;
    count_acks(63, 0, cnt);
    chk("credit_63_sends", 64'(cnt), 64'(63));
    bus.credit_update = 6'b000001;
    #2 chk("coincide_ack", 64'(bus.ack_interface2user), 64'(1));
    cyc();
    bus.credit_update = '0;
    count_acks(80, 0, cnt);
    chk("coincide_credit", 64'(cnt), 64'(64));
    setd(2, 32'hCAFEF00D);
    bus.vld_user2interface = 6'b000100;
    bus.dout_ready = 1'b0;
    cyc();
    repeat (5) begin
      #2;
      chk("bp_dout", 64'(bus.dout_packet), 64'(pk(2, 2, 2, 32'hCAFEF00D)));
      chk("bp_ack", 64'(bus.ack_interface2user), 64'(0));
      cyc();
    end
    bus.resend = 1'b1;
    bus.dout_ready = 1'b1;
    #2 chk("resend_ack", 64'(bus.ack_interface2user), 64'(0));
    cyc();
    #2 chk("resend_drain", 64'(bus.dout_packet), 64'(0));
    chk("resend_ack2", 64'(bus.ack_interface2user), 64'(0));
    cyc();
    bus.resend = 1'b0;
    #2 chk("resume_ack", 64'(bus.ack_interface2user), 64'(4));
    cyc();
    #2 chk("resume_pkt", 64'(bus.dout_packet), 64'(pk(2, 2, 3, 32'hCAFEF00D)));
    cyc();
    bus.vld_user2interface = '0;
    cfg(4, 7, 9);
    setd(4, 32'h0BADF00D);
    bus.vld_user2interface = 6'b010000;
    repeat (3) cyc();
    bus.cfg_we = 1'b1;
    bus.cfg_port = 4'd4;
    bus.cfg_dest_leaf = 5'd10;
    bus.cfg_dest_port = 4'd11;
    #2 chk("cfgcol_ack", 64'(bus.ack_interface2user), 64'(16));
    cyc();
    bus.cfg_we = 1'b0;
    #2 chk("cfgcol_old_route", 64'(bus.dout_packet), 64'(pk(7, 9, 3, 32'h0BADF00D)));
    cyc();
    #2 chk("cfgcol_new_route", 64'(bus.dout_packet), 64'(pk(10, 11, 0, 32'h0BADF00D)));
    cyc();
    bus.cfg_we = 1'b1;
    bus.cfg_port = 4'd15;
    bus.cfg_dest_leaf = 5'd1;
    bus.cfg_dest_port = 4'd1;
    cyc();
    bus.cfg_we = 1'b0;
    cyc();
    #2 chk("cfg15_ignored", 64'(bus.dout_packet), 64'(pk(10, 11, 3, 32'h0BADF00D)));
    cyc();
    bus.vld_user2interface = '0;
    for (int p = 0; p < N; p++) cfg(p, p + 1, p);
    acked = '0;
    repeat (3000) begin
      reset = ($urandom_range(299) == 0);
      bus.dout_ready = ($urandom_range(3) != 0);
      bus.resend = ($urandom_range(9) == 0);
      for (int p = 0; p < N; p++) bus.credit_update[p] = ($urandom_range(9) == 0);
      bus.cfg_we = ($urandom_range(29) == 0);
      bus.cfg_port = 4'($urandom_range(15));
      bus.cfg_dest_leaf = 5'($urandom);
      bus.cfg_dest_port = 4'($urandom);
      for (int p = 0; p < N; p++) begin
        if (acked[p] || !bus.vld_user2interface[p]) begin
          bus.vld_user2interface[p] = ($urandom_range(1) == 1);
          setd(p, $urandom);
        end
      end
      #2 acked = bus.ack_interface2user;
      cyc();
    end
    reset = 1'b0;
    bus.cfg_we = 1'b0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
